// File: rtl/numbotron_pkg.sv
// Shared types and instruction-word field helpers for the numbotron sequencer.
// Word layout is {inc, dec, zero}, each field NREGS bits; a word whose zero field is 0 is END.
package numbotron_pkg;

  localparam int MAXREGS = 32;
  localparam int MAXWORD = 3 * MAXREGS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  typedef logic [MAXWORD-1:0] word_max_t;
  typedef logic [MAXREGS-1:0] field_max_t;

  function automatic field_max_t field_mask(input int nregs);
    field_max_t m;
    m = '0;
    for (int i = 0; i < MAXREGS; i++) begin
      if (i < nregs) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Callers zero-extend their word into word_max_t and truncate the result back to NREGS.
  function automatic field_max_t insn_field(input word_max_t word, input int nregs, input int idx);
    word_max_t sh;
    sh = word >> (idx * nregs);
    return field_max_t'(sh) & field_mask(nregs);
  endfunction

  function automatic field_max_t insn_zero(input word_max_t word, input int nregs);
    return insn_field(word, nregs, 0);
  endfunction

  function automatic field_max_t insn_dec(input word_max_t word, input int nregs);
    return insn_field(word, nregs, 1);
  endfunction

  function automatic field_max_t insn_inc(input word_max_t word, input int nregs);
    return insn_field(word, nregs, 2);
  endfunction

  function automatic logic insn_is_end(input word_max_t word, input int nregs);
    return insn_zero(word, nregs) == '0;
  endfunction

endpackage

// File: rtl/numbotron_prog_mem.sv
// Program store: NINSN words in flops, one write port, single-cycle clear,
// and two combinational read ports (sequencer fetch and UI inspection).
module numbotron_prog_mem #(
  parameter int NREGS = 8,
  parameter int NINSN = 24,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [3*NREGS-1:0]   wdata,
  input  logic                 clear,
  input  logic [AW-1:0]        raddr_a,
  output logic [3*NREGS-1:0]   rdata_a,
  input  logic [AW-1:0]        raddr_b,
  output logic [3*NREGS-1:0]   rdata_b
);

  logic [3*NREGS-1:0] mem [NINSN];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NINSN; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < NINSN)) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses past the end of the store read as an END word.
  assign rdata_a = (int'(raddr_a) < NINSN) ? mem[raddr_a] : '0;
  assign rdata_b = (int'(raddr_b) < NINSN) ? mem[raddr_b] : '0;

endmodule

// File: rtl/numbotron_sequencer.sv
// Counter-machine instruction sequencer: fetches {inc,dec,zero} words, repeats the
// inc/dec op through a valid/ack handshake until a tested register reads zero.
module numbotron_sequencer
  import numbotron_pkg::*;
#(
  parameter  int NREGS = 8,
  parameter  int NINSN = 24,
  parameter  int LOOPW = 8,
  localparam int AW    = (NINSN > 1) ? $clog2(NINSN) : 1,
  localparam int WW    = 3 * NREGS
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               tick,
  input  logic               start,
  input  logic               halt,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic [LOOPW-1:0]   loop_count,
  input  logic [NREGS-1:0]   reg_zero,
  input  logic               op_ack,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_waddr,
  input  logic [WW-1:0]      prog_wdata,
  input  logic               prog_clear,
  input  logic [AW-1:0]      prog_raddr,
  output logic [WW-1:0]      prog_rdata,
  output logic               op_valid,
  output logic [NREGS-1:0]   inc_regs,
  output logic [NREGS-1:0]   dec_regs,
  output logic [AW-1:0]      ip,
  output logic               running,
  output logic [LOOPW:0]     loop_remain,
  output logic               done,
  output logic               wr_err,
  output state_t             dbg_state
);

  state_t           state;
  logic [WW-1:0]    fetch_word;
  logic [NREGS-1:0] f_zero, f_dec, f_inc;
  logic [NREGS-1:0] lat_zero, lat_dec, lat_inc;
  logic             f_end;
  logic             step_pend, halt_pend, wrap_pend;
  logic             ip_at_last, fetch_go;
  logic [AW-1:0]    ip_next;
  logic             mem_we, mem_clear, wr_bad, waddr_ok;

  assign running   = (state != ST_IDLE);
  assign dbg_state = state;

  assign f_zero = NREGS'(insn_zero(word_max_t'(fetch_word), NREGS));
  assign f_dec  = NREGS'(insn_dec(word_max_t'(fetch_word), NREGS));
  assign f_inc  = NREGS'(insn_inc(word_max_t'(fetch_word), NREGS));
  assign f_end  = insn_is_end(word_max_t'(fetch_word), NREGS);

  assign ip_at_last = (int'(ip) == NINSN - 1);
  assign ip_next    = ip_at_last ? '0 : ip + AW'(1);
  assign fetch_go   = tick && (!step_mode || step_pend);

  // The store is only editable while idle; clear beats a coincident write.
  assign waddr_ok  = (int'(prog_waddr) < NINSN);
  assign mem_clear = prog_clear && !running;
  assign mem_we    = prog_we && !prog_clear && !running && waddr_ok;
  assign wr_bad    = (running && (prog_we || prog_clear)) ||
                     (!running && !prog_clear && prog_we && !waddr_ok);

  numbotron_prog_mem #(
    .NREGS (NREGS),
    .NINSN (NINSN),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (prog_waddr),
    .wdata   (prog_wdata),
    .clear   (mem_clear),
    .raddr_a (ip),
    .rdata_a (fetch_word),
    .raddr_b (prog_raddr),
    .rdata_b (prog_rdata)
  );

  // Handshake: op_valid rises with the masks, both hold unchanged until a cycle with
  // op_valid && op_ack, and both clear on the edge that accepts the ack.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      ip          <= '0;
      op_valid    <= 1'b0;
      inc_regs    <= '0;
      dec_regs    <= '0;
      loop_remain <= '0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
      step_pend   <= 1'b0;
      halt_pend   <= 1'b0;
      wrap_pend   <= 1'b0;
      lat_zero    <= '0;
      lat_dec     <= '0;
      lat_inc     <= '0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_bad;
      if (step_req && step_mode) step_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          halt_pend <= 1'b0;
          wrap_pend <= 1'b0;
          if (start && !halt) begin
            loop_remain <= (LOOPW + 1)'(loop_count);
            ip          <= '0;
            state       <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (halt) begin
            state <= ST_IDLE;
          end else if (fetch_go) begin
            // Consuming here also drops a request arriving this cycle, so bursts collapse.
            step_pend <= 1'b0;
            if (f_end || wrap_pend) begin
              ip        <= '0;
              wrap_pend <= 1'b0;
              if (loop_remain == '0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                loop_remain <= loop_remain - (LOOPW + 1)'(1);
              end
            end else if ((f_zero & reg_zero) != '0) begin
              ip        <= ip_next;
              wrap_pend <= ip_at_last;
            end else begin
              lat_zero <= f_zero;
              lat_dec  <= f_dec;
              lat_inc  <= f_inc;
              state    <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          if (halt) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if ((lat_zero & reg_zero) != '0) begin
              ip        <= ip_next;
              wrap_pend <= ip_at_last;
              state     <= ST_FETCH;
            end else begin
              op_valid <= 1'b1;
              inc_regs <= lat_inc;
              dec_regs <= lat_dec;
              state    <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (halt) halt_pend <= 1'b1;
          if (op_valid && op_ack) begin
            op_valid <= 1'b0;
            inc_regs <= '0;
            dec_regs <= '0;
            state    <= (halt_pend || halt) ? ST_IDLE : ST_EXEC;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_numbotron_sequencer.sv
// Directed bench for numbotron_sequencer: a register-bank model acks ops, and a
// monitor checks every handshake against a queue of expected {inc,dec} masks.
module tb_numbotron_sequencer;
  import numbotron_pkg::*;

  localparam int NREGS = 8;
  localparam int NINSN = 24;
  localparam int LOOPW = 8;
  localparam int AW    = 5;
  localparam int WW    = 24;

  // clock / reset and DUT signals
  logic               clk = 1'b0;
  logic               rstb;
  logic               tick, start, halt, step_mode, step_req, op_ack;
  logic [LOOPW-1:0]   loop_count;
  logic [NREGS-1:0]   reg_zero;
  logic               prog_we, prog_clear;
  logic [AW-1:0]      prog_waddr, prog_raddr;
  logic [WW-1:0]      prog_wdata, prog_rdata;
  logic               op_valid, running, done, wr_err;
  logic [NREGS-1:0]   inc_regs, dec_regs;
  logic [AW-1:0]      ip;
  logic [LOOPW:0]     loop_remain;
  state_t             dbg_state;

  always #5 clk = ~clk;

  numbotron_sequencer #(.NREGS(NREGS), .NINSN(NINSN), .LOOPW(LOOPW)) dut (
    .clk(clk), .rstb(rstb), .tick(tick), .start(start), .halt(halt),
    .step_mode(step_mode), .step_req(step_req), .loop_count(loop_count),
    .reg_zero(reg_zero), .op_ack(op_ack), .prog_we(prog_we),
    .prog_waddr(prog_waddr), .prog_wdata(prog_wdata), .prog_clear(prog_clear),
    .prog_raddr(prog_raddr), .prog_rdata(prog_rdata), .op_valid(op_valid),
    .inc_regs(inc_regs), .dec_regs(dec_regs), .ip(ip), .running(running),
    .loop_remain(loop_remain), .done(done), .wr_err(wr_err), .dbg_state(dbg_state)
  );

  // scoreboard state and register-bank model
  int                 n_checks = 0;
  int                 n_pass   = 0;
  logic [2*NREGS-1:0] exp_q[$];
  int                 regs[NREGS];
  int                 ack_delay = 0;
  bit                 reload_on_pass = 1'b0;
  int                 hs_cnt = 0;
  int                 done_cnt = 0;
  int                 lr_dec_cnt = 0;
  bit                 saw_ip1 = 1'b0;

  always_comb begin
    reg_zero = '0;
    for (int i = 0; i < NREGS; i++) reg_zero[i] = (regs[i] == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bank_loop();
    int cnt = 0;
    logic [LOOPW:0] prev_lr = '0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        op_ack = 1'b0;
        cnt = 0;
      end else if (op_ack) begin
        op_ack = 1'b0;
      end else if (op_valid) begin
        if (cnt >= ack_delay) begin
          for (int i = 0; i < NREGS; i++) begin
            if (inc_regs[i]) regs[i] = regs[i] + 1;
            if (dec_regs[i] && regs[i] > 0) regs[i] = regs[i] - 1;
          end
          op_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      if (reload_on_pass && rstb && running && loop_remain != prev_lr) regs[0] = 3;
      prev_lr = loop_remain;
    end
  endtask

  task automatic monitor_loop();
    logic               prev_valid = 1'b0;
    logic [2*NREGS-1:0] held = '0;
    logic [LOOPW:0]     prev_lr = '0;
    forever begin
      @(negedge clk);
      if (op_valid && !prev_valid) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_op: got inc=0x%0h dec=0x%0h, expected no op", inc_regs, dec_regs);
        end else begin
          held = exp_q.pop_front();
          check("op_masks", {inc_regs, dec_regs}, held);
        end
      end else if (op_valid) begin
        check("op_masks_hold", {inc_regs, dec_regs}, held);
      end
      if (done) done_cnt++;
      if (running && ip == 1) saw_ip1 = 1'b1;
      if (running && int'(loop_remain) + 1 == int'(prev_lr)) lr_dec_cnt++;
      prev_lr = loop_remain;
      prev_valid = op_valid;
    end
  endtask

  // driver tasks
  task automatic prog_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
    prog_we = 1'b1; prog_waddr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_clear();
    prog_clear = 1'b1;
    @(negedge clk);
    prog_clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [AW-1:0] a, input logic [WW-1:0] d);
    prog_raddr = a;
    #1;
    check(name, prog_rdata, d);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (running && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (running) begin
      n_checks++;
      $display("FAIL %s: still running after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!op_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!op_valid) begin
      n_checks++;
      $display("FAIL %s: op_valid=0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic clear_counts();
    hs_cnt = 0; done_cnt = 0; lr_dec_cnt = 0; saw_ip1 = 1'b0;
  endtask

  task automatic set_regs(input int r0, input int r1, input int r3);
    for (int i = 0; i < NREGS; i++) regs[i] = 0;
    regs[0] = r0; regs[1] = r1; regs[3] = r3;
  endtask

  initial begin
    rstb = 1'b0; tick = 1'b1; start = 1'b0; halt = 1'b0; step_mode = 1'b0;
    step_req = 1'b0; op_ack = 1'b0; loop_count = '0; prog_we = 1'b0;
    prog_waddr = '0; prog_wdata = '0; prog_clear = 1'b0; prog_raddr = '0;
    set_regs(0, 0, 0);
    fork
      monitor_loop();
      bank_loop();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("rst_op_valid", op_valid, 0);
    check("rst_ip", ip, 0);
    check("rst_running", running, 0);
    check("rst_loop_remain", loop_remain, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_masks", {inc_regs, dec_regs}, 0);
    rstb = 1'b1;
    @(negedge clk);

    // test 1: single pass, reg0=3 gives three dec/inc ops
    pulse_clear();
    prog_write(0, 24'h0a0101);
    prog_write(1, 24'h000000);
    set_regs(3, 0, 0);
    clear_counts();
    repeat (3) exp_q.push_back({8'h0a, 8'h01});
    pulse_start();
    wait_idle("t1_finish", 200);
    repeat (2) @(negedge clk);
    check("t1_handshakes", hs_cnt, 3);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_done_low", done, 0);
    check("t1_reached_ip1", saw_ip1, 1);
    check("t1_ip_end", ip, 0);
    check("t1_exp_empty", exp_q.size(), 0);

    // test 2: two extra passes, bank reloads reg0 each pass
    set_regs(3, 0, 0);
    reload_on_pass = 1'b1;
    loop_count = 8'd2;
    clear_counts();
    repeat (9) exp_q.push_back({8'h0a, 8'h01});
    pulse_start();
    wait_idle("t2_finish", 400);
    repeat (2) @(negedge clk);
    reload_on_pass = 1'b0;
    loop_count = '0;
    check("t2_handshakes", hs_cnt, 9);
    check("t2_pass_restarts", lr_dec_cnt, 2);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_loop_remain", loop_remain, 0);
    check("t2_exp_empty", exp_q.size(), 0);

    // test 3: slow ack holds the request; halt in WAIT finishes the handshake only
    set_regs(3, 0, 0);
    ack_delay = 5;
    clear_counts();
    exp_q.push_back({8'h0a, 8'h01});
    pulse_start();
    wait_valid("t3_first_op", 50);
    for (int i = 0; i < 5; i++) begin
      check("t3_valid_held", op_valid, 1);
      if (i == 1) halt = 1'b1;
      if (i == 2) halt = 1'b0;
      @(negedge clk);
    end
    wait_idle("t3_halt", 50);
    repeat (2) @(negedge clk);
    ack_delay = 0;
    check("t3_handshakes", hs_cnt, 1);
    check("t3_no_done", done_cnt, 0);
    check("t3_state_idle", dbg_state, ST_IDLE);
    check("t3_exp_empty", exp_q.size(), 0);

    // test 4: single-step mode, one fetch per request, bursts collapse
    prog_write(0, 24'h000808);
    prog_write(1, 24'h040202);
    prog_write(2, 24'h000000);
    set_regs(0, 1, 2);
    step_mode = 1'b1;
    clear_counts();
    exp_q.push_back({8'h00, 8'h08});
    exp_q.push_back({8'h00, 8'h08});
    exp_q.push_back({8'h04, 8'h02});
    pulse_start();
    repeat (6) @(negedge clk);
    check("t4_no_fetch_ip", ip, 0);
    check("t4_no_fetch_ops", hs_cnt, 0);
    check("t4_waiting", dbg_state, ST_FETCH);
    pulse_step();
    repeat (20) @(negedge clk);
    check("t4_step1_ops", hs_cnt, 2);
    check("t4_step1_ip", ip, 1);
    step_req = 1'b1;
    repeat (2) @(negedge clk);
    step_req = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_burst_ops", hs_cnt, 3);
    check("t4_burst_ip", ip, 2);
    check("t4_burst_waiting", dbg_state, ST_FETCH);
    pulse_step();
    repeat (4) @(negedge clk);
    check("t4_running", running, 0);
    check("t4_done_pulses", done_cnt, 1);
    check("t4_exp_empty", exp_q.size(), 0);

    // test 5: edits rejected while running, accepted while idle
    set_regs(0, 0, 0);
    clear_counts();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_step();
    repeat (3) @(negedge clk);
    check("t5_skip_ip", ip, 1);
    prog_write(2, 24'habcdef);
    check("t5_we_run_err", wr_err, 1);
    check_word("t5_we_run_kept", 2, 24'h000000);
    @(negedge clk);
    check("t5_err_one_cycle", wr_err, 0);
    pulse_clear();
    check("t5_clr_run_err", wr_err, 1);
    check_word("t5_clr_run_kept", 0, 24'h000808);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("t5_halt_idle", running, 0);
    check("t5_halt_ip_kept", ip, 1);
    check("t5_halt_no_done", done_cnt, 0);
    step_mode = 1'b0;
    prog_write(5'd30, 24'h111111);
    check("t5_oob_err", wr_err, 1);
    prog_write(5, 24'h123456);
    check("t5_idle_we_ok", wr_err, 0);
    check_word("t5_idle_we_data", 5, 24'h123456);
    prog_we = 1'b1; prog_waddr = 5; prog_wdata = 24'h654321; prog_clear = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; prog_clear = 1'b0;
    check("t5_clear_err", wr_err, 0);
    for (int a = 0; a < NINSN; a++) check_word("t5_cleared", AW'(a), 24'h000000);
    start = 1'b1; halt = 1'b1;
    @(negedge clk);
    start = 1'b0; halt = 1'b0;
    check("t5_start_halt", running, 0);

    // test 6: async reset mid-handshake, program survives and reruns
    prog_write(0, 24'h0a0101);
    prog_write(1, 24'h000000);
    set_regs(3, 0, 0);
    ack_delay = 10;
    clear_counts();
    repeat (3) exp_q.push_back({8'h0a, 8'h01});
    pulse_start();
    wait_valid("t6_first_op", 50);
    #2;
    rstb = 1'b0;
    #1;
    check("t6_rst_valid", op_valid, 0);
    check("t6_rst_ip", ip, 0);
    check("t6_rst_running", running, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    exp_q.delete();
    check_word("t6_prog_kept", 0, 24'h0a0101);
    @(negedge clk);
    set_regs(3, 0, 0);
    ack_delay = 1;
    clear_counts();
    repeat (3) exp_q.push_back({8'h0a, 8'h01});
    pulse_start();
    wait_idle("t6_rerun", 300);
    repeat (2) @(negedge clk);
    check("t6_handshakes", hs_cnt, 3);
    check("t6_done_pulses", done_cnt, 1);
    check("t6_exp_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/numbotron_sequencer.md
Name: numbotron_sequencer

Overview:
Parametrised successor to the numbotron thread engine. It is a counter-machine instruction sequencer with three features:
- an NINSN-deep program store with a word write port and a UI read port;
- run and single-step modes, plus a loop count;
- an explicit valid/ack handshake to the register-file block for every inc/dec micro-step.

It sits between the UI/editor (program writes, start/halt/step) and the register bank (zero flags in, inc/dec masks out).

Parameters:
NREGS, 8, number of registers; each instruction field is NREGS bits wide.
NINSN, 24, program depth; address width AW = clog2(NINSN).
LOOPW, 8, loop-count width.

Ports:
clk  in  1  clock
rstb  in  1  asynchronous active-low reset
tick  in  1  slow-clock enable; all sequencing decisions are taken only on cycles with tick=1
start  in  1  pulse; begin execution from ip=0
halt  in  1  pulse; stop execution
step_mode  in  1  1 = single-step, 0 = free run
step_req  in  1  pulse; permit one instruction fetch in step mode
loop_count  in  LOOPW  extra program passes after the first
reg_zero  in  NREGS  bit i = 1 when register i is zero
op_ack  in  1  register bank has applied the current op
prog_we  in  1  program write strobe
prog_waddr  in  AW  write address
prog_wdata  in  3*NREGS  word {inc, dec, zero}
prog_clear  in  1  clear the whole program store
prog_raddr  in  AW  UI read address
prog_rdata  out  3*NREGS  combinational read of prog_raddr
op_valid  out  1  inc/dec request valid
inc_regs  out  NREGS  increment mask
dec_regs  out  NREGS  decrement mask
ip  out  AW  instruction pointer
running  out  1  1 in every state except IDLE
loop_remain  out  LOOPW+1  remaining passes
done  out  1  one-cycle pulse on normal completion
wr_err  out  1  one-cycle pulse when a write or clear is rejected

Behaviour:
Reset:
- state=IDLE; ip=0; running=0; op_valid=0; inc/dec=0; loop_remain=0; done=0; wr_err=0; step pending=0.
- Program store is not reset.

Instruction word: zero=[NREGS-1:0], dec=[2N-1:N], inc=[3N-1:2N]. A word with zero==0 is END.

States: IDLE, FETCH, EXEC, WAIT.

IDLE:
- start → loop_remain<=loop_count, ip<=0, FETCH.
- If start and halt are asserted together, halt wins and the block stays in IDLE.

FETCH (tick=1, and in step mode a pending step):
- Consume the pending step.
- If END, or ip was NINSN-1 and has advanced (wrap):
  - ip<=0;
  - if loop_remain==0 → IDLE, done=1;
  - else loop_remain-1, stay in FETCH.
- Else if (zero & reg_zero)!=0 → skip: ip<=ip+1, stay in FETCH.
- Else latch the word → EXEC.

EXEC (tick=1):
- If (latched zero & reg_zero)!=0 → ip<=ip+1, FETCH.
- Else op_valid<=1, inc_regs/dec_regs<=latched masks → WAIT.

WAIT:
- op_valid and the masks hold steady until op_ack; op_ack is sampled only while op_valid=1.
- On ack: op_valid<=0, masks<=0, EXEC.
- The bank must update reg_zero before the next tick.

Step pending:
- Set by step_req in any state; cleared when consumed.
- Multiple requests before consumption collapse to one.
- Ignored when step_mode=0.

halt:
- From FETCH or EXEC → IDLE at the next edge; ip is preserved.
- In WAIT, halt is latched; the block completes the handshake, then goes to IDLE.
- done is not pulsed on halt.

Program writes:
- prog_we and prog_clear take effect only when running=0; a clear zeroes all words in one cycle.
- When running=1 they are ignored and wr_err=1 for one cycle.
- If prog_we and prog_clear are asserted together, clear wins.
- prog_waddr >= NINSN → write ignored, wr_err=1.

Arithmetic: ip wraps modulo NINSN. loop_remain is unsigned, and the loop-exit test happens before the decrement.

Reset mid-handshake: op_valid drops immediately (async). The register bank must tolerate a dropped request.

Decomposition:
- numbotron_pkg:
  - state enum;
  - functions insn_zero/insn_dec/insn_inc(word, NREGS);
  - END test;
  - localparam widths.
- Sub-module numbotron_prog_mem: NINSN x 3*NREGS flop array, one write port, synchronous clear, two combinational read ports (ip, prog_raddr).

Test Plan:
All tests use NREGS=8, NINSN=24, tick tied to 1.
1. Program [0]=0x0a0101, [1]=0; bench model reg0=3; start → exactly 3 handshakes with inc=0x0a, dec=0x01; then ip=1; done pulse; running=0.
2. Same program with loop_count=2 → ip returns to 0 twice; 9 handshakes total; done once; loop_remain ends at 0.
3. Ack delayed 5 cycles → op_valid, inc and dec stay stable for all 5 cycles. Halt during WAIT → one handshake completes, then IDLE with no done pulse.
4. step_mode=1, program [0]=0x000808, [1]=0x040202, [2]=0 → no fetch until step_req. Each step_req advances exactly one instruction fetch, and double pulses collapse to one.
5. prog_we while running → wr_err pulse and word unchanged. prog_clear while idle → all prog_rdata reads 0.
6. Assert rstb low while op_valid=1 → op_valid=0, ip=0 and running=0 immediately. The program contents persist and re-run correctly after start.
